// File: rtl/sram_access_sequencer.sv
// sram_access_sequencer
//   Sole owner of the external 8-bit SRAM control strobes. Arbitrates single-byte
//   accesses between the acquisition byte stream and MCU register-driven
//   writes/reads. Produces the WE_n / OE_n / DQ-drive sequence and a one-cycle
//   address-counter increment after every completed access.
//
// Ports
//   CLOCK, RESET                 master clock (posedge), async active-high reset
//   ACQ_WR, ACQ_DATA             one-cycle acquisition byte strobe + data
//   MCU_WR_REQ/DATA/ACK          level write request, one-cycle completion ack
//   MCU_RD_REQ/ACK, MCU_RD_DATA  level read request, ack, last byte read
//   SRAM_FULL                    full flag from the address counter
//   SRAM_DQ_IN/OUT, SRAM_DQ_OE   SRAM data bus sample / drive value / drive enable
//   SRAM_WE_n, SRAM_OE_n         SRAM strobes, active low
//   ADDR_INC                     one-cycle increment strobe to the address counter
//   BUSY                         high whenever an access is in progress
//   ACQ_OVERRUN, WR_DISCARD      sticky error flags, cleared by FLAG_CLR
module sram_access_sequencer #(
    parameter int WR_PULSE_CYCLES = 2,
    parameter int RD_WAIT_CYCLES  = 2
) (
    input  logic       CLOCK,
    input  logic       RESET,
    input  logic       ACQ_WR,
    input  logic [7:0] ACQ_DATA,
    input  logic       MCU_WR_REQ,
    input  logic [7:0] MCU_WR_DATA,
    output logic       MCU_WR_ACK,
    input  logic       MCU_RD_REQ,
    output logic       MCU_RD_ACK,
    output logic [7:0] MCU_RD_DATA,
    input  logic       SRAM_FULL,
    input  logic [7:0] SRAM_DQ_IN,
    output logic [7:0] SRAM_DQ_OUT,
    output logic       SRAM_DQ_OE,
    output logic       SRAM_WE_n,
    output logic       SRAM_OE_n,
    output logic       ADDR_INC,
    output logic       BUSY,
    output logic       ACQ_OVERRUN,
    output logic       WR_DISCARD,
    input  logic       FLAG_CLR
);

    localparam int MAX_WAIT = (WR_PULSE_CYCLES > RD_WAIT_CYCLES) ? WR_PULSE_CYCLES : RD_WAIT_CYCLES;
    localparam int CNT_W    = $clog2(MAX_WAIT + 1);

    // Counters are loaded with N-1 and the state exits when they reach zero.
    localparam logic [CNT_W-1:0] WR_RELOAD = CNT_W'(WR_PULSE_CYCLES - 1);
    localparam logic [CNT_W-1:0] RD_RELOAD = CNT_W'(RD_WAIT_CYCLES - 1);

    localparam logic [2:0] IDLE     = 3'd0;
    localparam logic [2:0] WR_SETUP = 3'd1;
    localparam logic [2:0] WR_PULSE = 3'd2;
    localparam logic [2:0] WR_HOLD  = 3'd3;
    localparam logic [2:0] INC      = 3'd4;
    localparam logic [2:0] RD_WAIT  = 3'd5;
    localparam logic [2:0] RD_LATCH = 3'd6;

    logic [2:0]       state, next_state;
    logic [CNT_W-1:0] wait_cnt, next_cnt;
    logic             mcu_wr_op;      // current write came from the MCU (ack on completion)
    logic             buf_valid;
    logic [7:0]       buf_data;

    logic             grant_acq, grant_wr, grant_rd;
    logic             acq_pending, acq_load, acq_drop, discard;
    logic [7:0]       acq_byte;

    // A byte arriving while idle with an empty buffer is granted directly, so
    // acquisition keeps its priority over MCU requests raised in the same cycle.
    assign acq_pending = buf_valid || ACQ_WR;
    assign acq_byte    = buf_valid ? buf_data : ACQ_DATA;

    // Load when the buffer is free: either empty and not bypassed, or being
    // emptied by this cycle's grant. Otherwise an incoming byte is lost.
    assign acq_load = ACQ_WR && (grant_acq ? buf_valid : !buf_valid);
    assign acq_drop = ACQ_WR && buf_valid && !grant_acq;
    assign discard  = (grant_acq || grant_wr) && SRAM_FULL;

    // NOTE: every signal written here gets a default first, so no path can
    // leave one unassigned and infer a latch.
    always_comb begin
        next_state = state;
        next_cnt   = wait_cnt;
        grant_acq  = 1'b0;
        grant_wr   = 1'b0;
        grant_rd   = 1'b0;
        case (state)
            IDLE: begin
                if (acq_pending) begin
                    grant_acq = 1'b1;
                end else if (MCU_WR_REQ && !MCU_WR_ACK) begin
                    // A discarded write acks while still IDLE; the request is
                    // still visible that cycle and must not be granted twice.
                    grant_wr = 1'b1;
                end else if (MCU_RD_REQ) begin
                    grant_rd = 1'b1;
                end
                if ((grant_acq || grant_wr) && !SRAM_FULL) begin
                    next_state = WR_SETUP;
                end else if (grant_rd) begin
                    next_state = RD_WAIT;
                    next_cnt   = RD_RELOAD;
                end
            end
            WR_SETUP: begin
                next_state = WR_PULSE;
                next_cnt   = WR_RELOAD;
            end
            WR_PULSE: begin
                if (wait_cnt == '0) next_state = WR_HOLD;
                else                next_cnt   = wait_cnt - 1'b1;
            end
            WR_HOLD:  next_state = INC;
            RD_WAIT: begin
                if (wait_cnt == '0) next_state = RD_LATCH;
                else                next_cnt   = wait_cnt - 1'b1;
            end
            RD_LATCH: next_state = INC;
            INC:      next_state = IDLE;
            default:  next_state = IDLE;
        endcase
    end

    // Strobes are registered from next_state so they change on the same edge
    // as the state they belong to, with no combinational path to the pins.
    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples pre-edge values regardless of statement order.
    always_ff @(posedge CLOCK or posedge RESET) begin
        if (RESET) begin
            state       <= IDLE;
            wait_cnt    <= '0;
            mcu_wr_op   <= 1'b0;
            buf_valid   <= 1'b0;
            buf_data    <= 8'h00;
            SRAM_WE_n   <= 1'b1;
            SRAM_OE_n   <= 1'b1;
            SRAM_DQ_OE  <= 1'b0;
            SRAM_DQ_OUT <= 8'h00;
            ADDR_INC    <= 1'b0;
            BUSY        <= 1'b0;
            MCU_WR_ACK  <= 1'b0;
            MCU_RD_ACK  <= 1'b0;
            MCU_RD_DATA <= 8'h00;
            ACQ_OVERRUN <= 1'b0;
            WR_DISCARD  <= 1'b0;
        end else begin
            state      <= next_state;
            wait_cnt   <= next_cnt;
            SRAM_WE_n  <= (next_state != WR_PULSE);
            SRAM_OE_n  <= !((next_state == RD_WAIT) || (next_state == RD_LATCH));
            SRAM_DQ_OE <= (next_state == WR_SETUP) || (next_state == WR_PULSE) ||
                          (next_state == WR_HOLD);
            ADDR_INC   <= (next_state == INC);
            BUSY       <= (next_state != IDLE);
            MCU_WR_ACK <= (grant_wr && SRAM_FULL) || ((state == WR_HOLD) && mcu_wr_op);
            MCU_RD_ACK <= (state == RD_LATCH);

            if (grant_acq) begin
                SRAM_DQ_OUT <= acq_byte;
                mcu_wr_op   <= 1'b0;
            end else if (grant_wr) begin
                SRAM_DQ_OUT <= MCU_WR_DATA;
                mcu_wr_op   <= 1'b1;
            end

            // Sample the bus at the end of the last OE_n-low cycle.
            if (state == RD_LATCH) MCU_RD_DATA <= SRAM_DQ_IN;

            if (acq_load) begin
                buf_valid <= 1'b1;
                buf_data  <= ACQ_DATA;
            end else if (grant_acq) begin
                buf_valid <= 1'b0;
            end

            // Set has priority over clear when both happen in one cycle.
            if (acq_drop)      ACQ_OVERRUN <= 1'b1;
            else if (FLAG_CLR) ACQ_OVERRUN <= 1'b0;
            if (discard)       WR_DISCARD  <= 1'b1;
            else if (FLAG_CLR) WR_DISCARD  <= 1'b0;
        end
    end

endmodule
